cv32e40x_lsu_resp_tracker: RTL and testbench



---
 rtl/cv32e40x_lsu_resp_tracker.sv | 140 ++++++++++++++
 tb/tb_cv32e40x_lsu_resp_tracker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_lsu_resp_tracker.sv
// In-order tracker of outstanding LSU bus transfers: early core responses for bufferable
// stores, zero-latency pass-through otherwise, sticky imprecise error capture for early stores.
module cv32e40x_lsu_resp_tracker #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 32,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // core side request
  input  logic                  valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic                  bufferable_i,
  output logic                  ready_o,
  // bus side request
  output logic                  valid_o,
  input  logic                  ready_i,
  // bus response
  input  logic                  resp_valid_i,
  input  logic                  resp_err_i,
  // core response
  output logic                  resp_valid_o,
  output logic                  resp_err_o,
  // imprecise error
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  input  logic                  err_ack_i,
  // status
  output logic [CNT_W-1:0]      bus_cnt_o,
  output logic                  busy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic                  early_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      bus_ptr;
  logic [PTR_W-1:0]      core_ptr;
  logic [CNT_W-1:0]      bus_cnt;
  logic [CNT_W-1:0]      core_cnt;
  logic                  err_valid;
  logic [ADDR_WIDTH-1:0] err_addr;

  logic not_full;
  logic push;
  logic retire;
  logic imp_err;

  assign not_full = (bus_cnt < DEPTH_CNT);
  assign valid_o  = valid_i && not_full;
  assign ready_o  = ready_i && not_full;
  assign push     = valid_o && ready_i;
  assign retire   = resp_valid_i && (bus_cnt != '0);
  assign imp_err  = retire && resp_err_i && early_q[bus_ptr];

  // A non-early head may only answer once it is also the oldest entry on the bus.
  always_comb begin
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    if (core_cnt != '0) begin
      if (early_q[core_ptr]) begin
        resp_valid_o = 1'b1;
      end else if (core_ptr == bus_ptr) begin
        resp_valid_o = resp_valid_i;
        resp_err_o   = resp_err_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        early_q[i] <= 1'b0;
        addr_q[i]  <= '0;
      end
    end else if (push) begin
      early_q[wr_ptr] <= we_i && bufferable_i;
      addr_q[wr_ptr]  <= addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      bus_ptr  <= '0;
      core_ptr <= '0;
    end else begin
      if (push)         wr_ptr   <= ptr_inc(wr_ptr);
      if (retire)       bus_ptr  <= ptr_inc(bus_ptr);
      if (resp_valid_o) core_ptr <= ptr_inc(core_ptr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_cnt  <= '0;
      core_cnt <= '0;
    end else begin
      case ({push, retire})
        2'b10:   bus_cnt <= bus_cnt + CNT_W'(1);
        2'b01:   bus_cnt <= bus_cnt - CNT_W'(1);
        default: bus_cnt <= bus_cnt;
      endcase
      case ({push, resp_valid_o})
        2'b10:   core_cnt <= core_cnt + CNT_W'(1);
        2'b01:   core_cnt <= core_cnt - CNT_W'(1);
        default: core_cnt <= core_cnt;
      endcase
    end
  end

  // First error wins until acknowledged; an ack coinciding with a new error re-arms on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (imp_err && (!err_valid || err_ack_i)) begin
      err_valid <= 1'b1;
      err_addr  <= addr_q[bus_ptr];
    end else if (err_ack_i) begin
      err_valid <= 1'b0;
    end
  end

  assign err_valid_o = err_valid;
  assign err_addr_o  = err_addr;
  assign bus_cnt_o   = bus_cnt;
  assign busy_o      = (bus_cnt != '0) || valid_i;

endmodule

// File: tb/tb_cv32e40x_lsu_resp_tracker.sv
// Directed checks of the response tracker at DEPTH=2 plus a modelled wrap-around run at DEPTH=3.
module tb_cv32e40x_lsu_resp_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DEPTH=2 instance
  logic        valid_i = 0, we_i = 0, bufferable_i = 0, ready_i = 0;
  logic        resp_valid_i = 0, resp_err_i = 0, err_ack_i = 0;
  logic [31:0] addr_i = '0;
  logic        ready_o, valid_o, resp_valid_o, resp_err_o, err_valid_o, busy_o;
  logic [31:0] err_addr_o;
  logic [1:0]  bus_cnt_o;

  cv32e40x_lsu_resp_tracker #(.DEPTH(2), .ADDR_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i), .addr_i(addr_i), .we_i(we_i), .bufferable_i(bufferable_i),
    .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
    .resp_valid_i(resp_valid_i), .resp_err_i(resp_err_i),
    .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o),
    .err_valid_o(err_valid_o), .err_addr_o(err_addr_o), .err_ack_i(err_ack_i),
    .bus_cnt_o(bus_cnt_o), .busy_o(busy_o)
  );

  // DEPTH=3 instance
  logic        d3_valid_i = 0, d3_we_i = 0, d3_buf_i = 0, d3_ready_i = 0;
  logic        d3_rv_i = 0, d3_re_i = 0, d3_ack_i = 0;
  logic [31:0] d3_addr_i = '0;
  logic        d3_ready_o, d3_valid_o, d3_rv_o, d3_re_o, d3_err_valid_o, d3_busy_o;
  logic [31:0] d3_err_addr_o;
  logic [1:0]  d3_bus_cnt_o;

  cv32e40x_lsu_resp_tracker #(.DEPTH(3), .ADDR_WIDTH(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .valid_i(d3_valid_i), .addr_i(d3_addr_i), .we_i(d3_we_i), .bufferable_i(d3_buf_i),
    .ready_o(d3_ready_o), .valid_o(d3_valid_o), .ready_i(d3_ready_i),
    .resp_valid_i(d3_rv_i), .resp_err_i(d3_re_i),
    .resp_valid_o(d3_rv_o), .resp_err_o(d3_re_o),
    .err_valid_o(d3_err_valid_o), .err_addr_o(d3_err_addr_o), .err_ack_i(d3_ack_i),
    .bus_cnt_o(d3_bus_cnt_o), .busy_o(d3_busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic we, input logic bf, input logic [31:0] a,
                     input logic rdy, input logic rv, input logic re, input logic ack);
    valid_i = v; we_i = we; bufferable_i = bf; addr_i = a;
    ready_i = rdy; resp_valid_i = rv; resp_err_i = re; err_ack_i = ack;
  endtask

  task automatic idle();
    drv(0, 0, 0, 32'h0, 1, 0, 0, 0);
  endtask

  // DEPTH=3 reference model state
  int  pushed = 0, bidx = 0, cidx = 0, outst = 0, max_cnt = 0;
  bit  early_m [10];
  bit  exp_rv, exp_re, do_push;

  initial begin
    // reset state
    #2;
    chk("rst_bus_cnt", bus_cnt_o, 0);
    chk("rst_err_valid", err_valid_o, 0);
    chk("rst_err_addr", err_addr_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_busy_idle", busy_o, 0);
    valid_i = 1; #1;
    chk("rst_busy_valid", busy_o, 1);
    valid_i = 0;
    nxt(); rst_n = 1;

    // two bufferable stores, early responses, then blocking
    nxt(); drv(1, 1, 1, 32'h100, 1, 0, 0, 0); mid();
    chk("t1_c0_ready", ready_o, 1); chk("t1_c0_resp", resp_valid_o, 0);
    nxt(); drv(1, 1, 1, 32'h104, 1, 0, 0, 0); mid();
    chk("t1_c1_resp", resp_valid_o, 1); chk("t1_c1_ready", ready_o, 1);
    nxt(); drv(1, 1, 1, 32'h108, 1, 0, 0, 0); mid();
    chk("t1_c2_resp", resp_valid_o, 1); chk("t1_c2_ready", ready_o, 0);
    chk("t1_c2_valid_o", valid_o, 0); chk("t1_c2_cnt", bus_cnt_o, 2);
    nxt(); idle(); mid(); chk("t1_c3_resp", resp_valid_o, 0);
    nxt(); idle(); mid(); chk("t1_c4_resp", resp_valid_o, 0); chk("t1_c4_cnt", bus_cnt_o, 2);
    nxt(); drv(0, 0, 0, 0, 1, 1, 0, 0); mid(); chk("t1_c5_resp", resp_valid_o, 0);
    nxt(); drv(0, 0, 0, 0, 1, 1, 0, 0); mid(); chk("t1_c6_resp", resp_valid_o, 0);
    chk("t1_c6_cnt", bus_cnt_o, 1);
    nxt(); idle(); mid(); chk("t1_c7_cnt", bus_cnt_o, 0); chk("t1_c7_resp", resp_valid_o, 0);

    // load then bufferable store: store waits behind the load
    nxt(); drv(1, 0, 0, 32'h200, 1, 0, 0, 0); mid(); chk("t2_c0_resp", resp_valid_o, 0);
    nxt(); drv(1, 1, 1, 32'h204, 1, 0, 0, 0); mid(); chk("t2_c1_resp", resp_valid_o, 0);
    nxt(); idle(); mid(); chk("t2_c2_resp", resp_valid_o, 0);
    nxt(); idle(); mid(); chk("t2_c3_resp", resp_valid_o, 0);
    nxt(); drv(0, 0, 0, 0, 1, 1, 0, 0); mid();
    chk("t2_c4_resp", resp_valid_o, 1); chk("t2_c4_err", resp_err_o, 0);
    nxt(); idle(); mid(); chk("t2_c5_resp", resp_valid_o, 1); chk("t2_c5_err", resp_err_o, 0);
    nxt(); idle(); mid(); chk("t2_c6_resp", resp_valid_o, 0);
    nxt(); drv(0, 0, 0, 0, 1, 1, 0, 0); mid(); chk("t2_c7_resp", resp_valid_o, 0);
    nxt(); idle(); mid(); chk("t2_c8_cnt", bus_cnt_o, 0);

    // imprecise errors on early-responded stores
    nxt(); drv(1, 1, 1, 32'h1000, 1, 0, 0, 0); mid();
    nxt(); idle(); mid(); chk("t3_early_resp", resp_valid_o, 1);
    nxt(); drv(0, 0, 0, 0, 1, 1, 1, 0); mid();
    chk("t3_err_not_yet", err_valid_o, 0); chk("t3_no_core_resp", resp_valid_o, 0);
    nxt(); drv(1, 1, 1, 32'h2000, 1, 0, 0, 0); mid();
    chk("t3_err_set", err_valid_o, 1); chk("t3_err_addr", err_addr_o, 32'h1000);
    nxt(); idle(); mid();
    nxt(); drv(0, 0, 0, 0, 1, 1, 1, 0); mid();
    nxt(); drv(0, 0, 0, 0, 1, 0, 0, 1); mid();
    chk("t3_err_kept", err_valid_o, 1); chk("t3_addr_kept", err_addr_o, 32'h1000);
    nxt(); drv(1, 1, 1, 32'h3000, 1, 0, 0, 0); mid(); chk("t3_ack_clr", err_valid_o, 0);
    nxt(); idle(); mid();
    nxt(); drv(0, 0, 0, 0, 1, 1, 1, 0); mid();
    nxt(); drv(1, 1, 1, 32'h4000, 1, 0, 0, 0); mid(); chk("t3_addr_3000", err_addr_o, 32'h3000);
    nxt(); idle(); mid();
    nxt(); drv(0, 0, 0, 0, 1, 1, 1, 1); mid();
    nxt(); drv(0, 0, 0, 0, 1, 0, 0, 1); mid();
    chk("t3_ack_new_valid", err_valid_o, 1); chk("t3_ack_new_addr", err_addr_o, 32'h4000);
    nxt(); idle(); mid(); chk("t3_final_clr", err_valid_o, 0);

    // non-bufferable store error is precise
    nxt(); drv(1, 1, 0, 32'h5000, 1, 0, 0, 0); mid(); chk("t4_no_early", resp_valid_o, 0);
    nxt(); drv(0, 0, 0, 0, 1, 1, 1, 0); mid();
    chk("t4_resp", resp_valid_o, 1); chk("t4_resp_err", resp_err_o, 1);
    nxt(); idle(); mid(); chk("t4_no_imp", err_valid_o, 0); chk("t4_cnt", bus_cnt_o, 0);

    // spurious response at idle
    nxt(); drv(0, 0, 0, 0, 1, 1, 1, 0); mid(); chk("sp_resp", resp_valid_o, 0);
    nxt(); idle(); mid(); chk("sp_cnt", bus_cnt_o, 0); chk("sp_err", err_valid_o, 0);

    // reset with outstanding transfers and a pending error
    nxt(); drv(1, 1, 1, 32'h6000, 1, 0, 0, 0); mid();
    nxt(); idle(); mid();
    nxt(); drv(0, 0, 0, 0, 1, 1, 1, 0); mid();
    nxt(); drv(1, 1, 1, 32'h7000, 1, 0, 0, 0); mid(); chk("rs_err_pre", err_valid_o, 1);
    nxt(); drv(1, 0, 0, 32'h7004, 1, 0, 0, 0); mid();
    nxt(); idle(); mid(); chk("rs_cnt_pre", bus_cnt_o, 2);
    valid_i = 0; rst_n = 0; #1;
    chk("rs_cnt", bus_cnt_o, 0); chk("rs_err_valid", err_valid_o, 0);
    chk("rs_err_addr", err_addr_o, 0); chk("rs_resp", resp_valid_o, 0); chk("rs_busy", busy_o, 0);
    nxt(); rst_n = 1; drv(0, 0, 0, 0, 1, 1, 0, 0); mid(); chk("rs_late_resp", resp_valid_o, 0);
    nxt(); idle(); mid(); chk("rs_late_cnt", bus_cnt_o, 0); chk("rs_late_busy", busy_o, 0);

    // DEPTH=3: 10 mixed transfers with random grant and response timing
    for (int cyc = 0; cyc < 400 && !(cidx == 10 && bidx == 10); cyc++) begin
      nxt();
      outst      = pushed - bidx;
      d3_valid_i = (pushed < 10);
      d3_we_i    = 1'($urandom_range(0, 1));
      d3_buf_i   = 1'($urandom_range(0, 1));
      d3_addr_i  = 32'(pushed * 4);
      d3_ready_i = 1'($urandom_range(0, 1));
      d3_rv_i    = (outst > 0) && ($urandom_range(0, 2) == 0);
      d3_re_i    = ($urandom_range(0, 3) == 0);
      d3_ack_i   = 1'b1;
      mid();
      exp_rv = 0; exp_re = 0;
      if (cidx < pushed) begin
        if (early_m[cidx]) exp_rv = 1;
        else if (bidx == cidx) begin exp_rv = d3_rv_i; exp_re = d3_re_i; end
      end
      chk("d3_resp_valid", d3_rv_o, exp_rv);
      if (exp_rv) chk("d3_resp_err", d3_re_o, exp_re);
      chk("d3_bus_cnt", d3_bus_cnt_o, outst);
      chk("d3_ready", d3_ready_o, d3_ready_i && (outst < 3));
      if (int'(d3_bus_cnt_o) > max_cnt) max_cnt = int'(d3_bus_cnt_o);
      do_push = d3_valid_i && d3_ready_i && (outst < 3);
      if (do_push) early_m[pushed] = d3_we_i && d3_buf_i;
      if (exp_rv) cidx++;
      if (d3_rv_i && outst > 0) bidx++;
      if (do_push) pushed++;
    end
    nxt();
    d3_valid_i = 0; d3_rv_i = 0; d3_re_i = 0; d3_ready_i = 0;
    mid();
    chk("d3_all_pushed", 32'(pushed), 10);
    chk("d3_all_core", 32'(cidx), 10);
    chk("d3_all_bus", 32'(bidx), 10);
    chk("d3_final_cnt", d3_bus_cnt_o, 0);
    chk("d3_final_busy", d3_busy_o, 0);
    chk("d3_max_cnt_le3", max_cnt <= 3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
